// File: rtl/universal_shift_reg_if.sv
// Command/data bundle for universal_shift_reg. The optional abort signal
// exists only when USR_ABORT_EN is defined.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] data_in;
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             serial_out;
    logic             busy;
    logic             done;
`ifdef USR_ABORT_EN
    logic             abort;
`endif

    modport master (
`ifdef USR_ABORT_EN
        output abort,
`endif
        output cmd_valid, cmd_op, cmd_cnt, data_in, serial_in,
        input  cmd_ready, data_out, serial_out, busy, done
    );

    modport slave (
`ifdef USR_ABORT_EN
        input  abort,
`endif
        input  cmd_valid, cmd_op, cmd_cnt, data_in, serial_in,
        output cmd_ready, data_out, serial_out, busy, done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-generic shift engine: load, shift/rotate/arith-shift over N steps with
// valid/ready command handshake. Define USR_ABORT_EN to add a mid-command abort.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    universal_shift_reg_if.slave  bus
);
    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ASR  = 3'b101;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             so_q, so_d;
    logic             done_q, done_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] step_data;
    logic             step_so;
    logic             accept;
    logic             abort_req;

    assign accept = bus.cmd_valid && (state_q == IDLE);

`ifdef USR_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // Single-bit step of the latched op; serial_in is sampled live here.
    always_comb begin
        step_data = data_q;
        step_so   = so_q;
        case (op_q)
            OP_SHL: begin
                step_data = {data_q[WIDTH-2:0], bus.serial_in};
                step_so   = data_q[WIDTH-1];
            end
            OP_SHR: begin
                step_data = {bus.serial_in, data_q[WIDTH-1:1]};
                step_so   = data_q[0];
            end
            OP_ROL: begin
                step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                step_so   = data_q[WIDTH-1];
            end
            OP_ROR: begin
                step_data = {data_q[0], data_q[WIDTH-1:1]};
                step_so   = data_q[0];
            end
            OP_ASR: begin
                step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                step_so   = data_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        so_d    = so_q;
        done_d  = 1'b0;
        op_d    = op_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_LOAD: begin
                            data_d = bus.data_in;
                            done_d = 1'b1;
                        end
                        OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: begin
                            if (bus.cmd_cnt == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = SHIFT;
                                op_d    = bus.cmd_op;
                                rem_d   = bus.cmd_cnt;
                            end
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            SHIFT: begin
                if (abort_req) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    data_d = step_data;
                    so_d   = step_so;
                    rem_d  = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= OP_LOAD;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            so_q    <= so_d;
            done_q  <= done_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q == SHIFT);
    assign bus.data_out   = data_q;
    assign bus.serial_out = so_q;
    assign bus.done       = done_q;
endmodule
